// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite types and constants for the memory slave and its helpers.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } Mem_Slave_state;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    // Holds WAIT_CYCLES (<=15) plus up to 3 random extra wait states.
    localparam int unsigned WAIT_CNT_W = 5;

endpackage

// File: rtl/ahb_wait_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) feeding pseudo-random wait states.
module ahb_wait_lfsr
    import ahb3lite_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       en,
    output logic [7:0] lfsr
);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-addressed memory slave with fixed wait states and ERROR responses.
// Define AHB_MEM_RAND_WAIT_EN to add 0..3 LFSR-driven extra wait states per transfer.
module ahb_mem_slave
    import ahb3lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  HTRANS_state HTRANS,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic        HREADY,
    output logic [31:0] mem_WR_addr,
    output logic        mem_write_flag,
    output logic [31:0] HWDATA_toMem
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Parameter legality, caught at elaboration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ahb_mem_slave: DEPTH must be a power of 2 and >= 2");
    end
    if (({1'b0, BASE_ADDR} + 33'(DEPTH)) > 33'h1_0000_0000) begin : g_bad_range
        $error("ahb_mem_slave: BASE_ADDR+DEPTH overflows the 32-bit address space");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("ahb_mem_slave: WAIT_CYCLES must be 0..15");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("ahb_mem_slave: LFSR_SEED must be non-zero");
    end

    logic [31:0]           mem [DEPTH];
    Mem_Slave_state        state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_load;
    logic [31:0]           addr_q;
    logic                  write_q;
    logic [31:0]           offset;
    logic [AW-1:0]         mem_idx;
    logic                  accept;
    logic                  legal;

    // Out-of-window addresses wrap to offsets >= DEPTH, so one compare covers both bounds.
    assign offset  = HADDR - BASE_ADDR;
    assign accept  = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign legal   = (offset < 32'(DEPTH)) && (HSIZE == HSIZE_WORD);
    assign mem_idx = AW'(addr_q - BASE_ADDR);

`ifdef AHB_MEM_RAND_WAIT_EN
    logic [7:0] lfsr;

    ahb_wait_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .en    (1'b1),
        .lfsr  (lfsr)
    );

    assign wait_load = WAIT_CNT_W'(WAIT_CYCLES) + WAIT_CNT_W'(lfsr[1:0]);
`else
    assign wait_load = WAIT_CNT_W'(WAIT_CYCLES);
`endif

    // Transfer FSM: address capture, wait countdown and two-cycle error response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
        end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
        end else if (state == ST_DATA && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
        end else if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            if (legal) begin
                state    <= ST_DATA;
                wait_cnt <= wait_load;
            end else begin
                state <= ST_ERR1;
            end
        end else begin
            state <= ST_IDLE;
        end
    end

    // Reset wins over a write completing in the same cycle.
    always_ff @(posedge HCLK) begin
        if (mem_write_flag && !HRESET) begin
            mem[mem_idx] <= HWDATA;
        end
    end

    assign HREADYOUT      = (state == ST_ERR1) ? 1'b0 :
                            (state == ST_DATA) ? (wait_cnt == '0) : 1'b1;
    assign HRESP          = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign mem_write_flag = (state == ST_DATA) && write_q && (wait_cnt == '0);
    assign mem_WR_addr    = addr_q;
    assign HWDATA_toMem   = HWDATA;
    assign HRDATA         = (state == ST_DATA && !write_q) ? mem[mem_idx] : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Table-driven bench: per-cycle bus vectors drive two slaves (0 and 2 wait states), a monitor checks.
module tb_ahb_mem_slave;
    import ahb3lite_pkg::*;

    typedef struct {
        int          idx;
        bit          d;
        bit          hs;
        bit          rs;
        HTRANS_state t;
        logic [31:0] a;
        bit          w;
        logic [2:0]  sz;
        logic [31:0] wd;
        bit          rdy;
        bit          rsp;
        bit          wf;
        logic [31:0] wa;
        logic [31:0] wde;
        bit          crd;
        logic [31:0] rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel1;
    HTRANS_state htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] rdata0, rdata1, waddr0, waddr1, wdout0, wdout1;
    logic        rdy0, rdy1, resp0, resp1, wf0, wf1;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t v;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    ahb_mem_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HTRANS(htrans), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(rdata0),
        .HREADYOUT(rdy0), .HRESP(resp0), .HREADY(rdy0), .mem_WR_addr(waddr0),
        .mem_write_flag(wf0), .HWDATA_toMem(wdout0)
    );

    ahb_mem_slave #(.WAIT_CYCLES(2)) u_dut2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel1), .HTRANS(htrans), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(rdata1),
        .HREADYOUT(rdy1), .HRESP(resp1), .HREADY(rdy1), .mem_WR_addr(waddr1),
        .mem_write_flag(wf1), .HWDATA_toMem(wdout1)
    );

    task automatic row(input bit d, input bit hs, input bit rs, input HTRANS_state t,
                       input logic [31:0] a, input bit w, input logic [2:0] sz,
                       input logic [31:0] wd, input bit rdy, input bit rsp, input bit wf,
                       input logic [31:0] wa, input logic [31:0] wde, input bit crd,
                       input logic [31:0] rd);
        vec_t r;
        r.idx = vecs.size();
        r.d = d; r.hs = hs; r.rs = rs; r.t = t; r.a = a; r.w = w; r.sz = sz; r.wd = wd;
        r.rdy = rdy; r.rsp = rsp; r.wf = wf; r.wa = wa; r.wde = wde; r.crd = crd; r.rd = rd;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Monitor: pop the expected record for this cycle and compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                v = sb.pop_front();
                chk("hreadyout", v.idx, {31'b0, v.d ? rdy1 : rdy0}, {31'b0, v.rdy});
                chk("hresp", v.idx, {31'b0, v.d ? resp1 : resp0}, {31'b0, v.rsp});
                chk("mem_write_flag", v.idx, {31'b0, v.d ? wf1 : wf0}, {31'b0, v.wf});
                if (v.wf) begin
                    chk("mem_WR_addr", v.idx, v.d ? waddr1 : waddr0, v.wa);
                    chk("HWDATA_toMem", v.idx, v.d ? wdout1 : wdout0, v.wde);
                end
                if (v.crd) chk("hrdata", v.idx, v.d ? rdata1 : rdata0, v.rd);
            end
        end
    end

    initial begin
        localparam HTRANS_state I = HTRANS_IDLE;
        localparam HTRANS_state B = HTRANS_BUSY;
        localparam HTRANS_state N = HTRANS_NONSEQ;
        localparam HTRANS_state S = HTRANS_SEQ;
        localparam logic [2:0]  W = HSIZE_WORD;
        int wait_cnt;

        // Zero-wait slave: idle, 4-beat write burst, readback, RAW, errors, BUSY.
        row(0,0,0,I, 0,0,W,0,             1,0,0, 0,0, 0,0);
        row(0,0,0,I, 0,0,W,0,             1,0,0, 0,0, 0,0);
        row(0,1,0,N,63,1,W,0,             1,0,0, 0,0, 0,0);
        row(0,1,0,S,62,1,W,5,             1,0,1,63,5, 0,0);
        row(0,1,0,S,61,1,W,6,             1,0,1,62,6, 0,0);
        row(0,1,0,S,60,1,W,7,             1,0,1,61,7, 0,0);
        row(0,1,0,I, 0,0,W,8,             1,0,1,60,8, 0,0);
        row(0,1,0,N,63,0,W,0,             1,0,0, 0,0, 1,0);
        row(0,1,0,S,62,0,W,0,             1,0,0, 0,0, 1,5);
        row(0,1,0,S,61,0,W,0,             1,0,0, 0,0, 1,6);
        row(0,1,0,S,60,0,W,0,             1,0,0, 0,0, 1,7);
        row(0,1,0,I, 0,0,W,0,             1,0,0, 0,0, 1,8);
        row(0,1,0,N, 5,1,W,0,             1,0,0, 0,0, 0,0);
        row(0,1,0,N, 5,0,W,32'h1234_5678, 1,0,1, 5,32'h1234_5678, 0,0);
        row(0,1,0,I, 0,0,W,0,             1,0,0, 0,0, 1,32'h1234_5678);
        row(0,1,0,N,64,1,W,0,             1,0,0, 0,0, 0,0);
        row(0,1,0,I, 0,0,W,32'hBAD,       0,1,0, 0,0, 0,0);
        row(0,1,0,I, 0,0,W,0,             1,1,0, 0,0, 0,0);
        row(0,1,0,N, 3,1,3'b001,0,        1,0,0, 0,0, 0,0);
        row(0,1,0,I, 0,0,W,0,             0,1,0, 0,0, 0,0);
        row(0,1,0,N,60,0,W,0,             1,1,0, 0,0, 0,0);
        row(0,1,0,I, 0,0,W,0,             1,0,0, 0,0, 1,8);
        row(0,1,0,B, 0,0,W,0,             1,0,0, 0,0, 1,0);
        row(0,1,0,I, 0,0,W,0,             1,0,0, 0,0, 1,0);
        // Two-wait slave: single write, read back, reset during a wait state.
        row(1,1,0,N,10,1,W,0,             1,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,32'hDEAD_BEEF, 0,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,32'hDEAD_BEEF, 0,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,32'hDEAD_BEEF, 1,0,1,10,32'hDEAD_BEEF, 0,0);
        row(1,1,0,N,10,0,W,0,             1,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,0,             0,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,0,             0,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,0,             1,0,0, 0,0, 1,32'hDEAD_BEEF);
        row(1,1,0,N,10,1,W,0,             1,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,32'h5555_AAAA, 0,0,0, 0,0, 0,0);
        row(1,1,1,I, 0,0,W,32'h5555_AAAA, 0,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,32'h5555_AAAA, 1,0,0, 0,0, 1,0);
        row(1,1,0,N,10,0,W,0,             1,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,0,             0,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,0,             0,0,0, 0,0, 0,0);
        row(1,1,0,I, 0,0,W,0,             1,0,0, 0,0, 1,32'hDEAD_BEEF);

        hreset = 1'b1; hsel0 = 1'b0; hsel1 = 1'b0; htrans = HTRANS_IDLE;
        haddr = '0; hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;
        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            #1;
            hreset = vecs[i].rs;
            hsel0  = vecs[i].hs && !vecs[i].d;
            hsel1  = vecs[i].hs && vecs[i].d;
            htrans = vecs[i].t;
            haddr  = vecs[i].a;
            hwrite = vecs[i].w;
            hsize  = vecs[i].sz;
            hwdata = vecs[i].wd;
            sb.push_back(vecs[i]);
            @(posedge clk);
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
